// File: rtl/spi_pkg.sv
// Shared constants for the Wishbone SPI master: register offsets, bit positions,
// FSM encoding and the divider reset value.
package spi_pkg;

  localparam logic [15:0] DIV_RST = 16'h0003;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CPOL   = 1;
  localparam int unsigned CTRL_CPHA   = 2;
  localparam int unsigned CTRL_IRQEN  = 3;
  localparam int unsigned CTRL_CS_LSB = 4;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_OVR  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_TRAIL = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// SCK half-period timebase: one-cycle half_tick every div+1 clocks while run is
// high; the counter sits at the reload value whenever run is low.
module spi_clkgen (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] div,
  output logic        half_tick
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run || cnt_q == '0) begin
      cnt_q <= div;
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign half_tick = run && (cnt_q == '0);

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone-slave SPI master: register file, single-byte full-duplex transfer FSM
// (modes 0-3), four chip selects and a done interrupt.
module wb_spi_master #(
  parameter int unsigned NCS     = 4,
  parameter logic [15:0] DIV_RST = spi_pkg::DIV_RST
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [7:0]     wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic           irq_o,
  output logic           sck_o,
  output logic           mosi_o,
  input  logic           miso_i,
  output logic [NCS-1:0] cs_n_o,
  output logic           spi_oeb_o
);

  import spi_pkg::*;

  localparam int unsigned NM = (NCS < 4) ? NCS : 4;

  logic        ack_q;
  logic [31:0] dat_q;
  logic        en_q, cpol_q, cpha_q, irqen_q;
  logic [3:0]  csm_q;
  logic [15:0] div_q;
  logic [7:0]  rx_q;
  logic        done_q, ovr_q;

  spi_state_e     state_q;
  logic           cpol_l, cpha_l;
  logic [15:0]    div_l;
  logic [NCS-1:0] cs_sel, cs_sel_l;
  logic [7:0]     tx_sh, rx_sh;
  logic [3:0]     edge_q;
  logic           sck_q;

  logic        acc, wr, rd, hit, busy;
  logic [1:0]  reg_sel;
  logic        wr_data, start, data_ovr, w1c_done, w1c_ovr;
  logic        half_tick, finish, abort, sample_edge;
  logic [15:0] div_src;
  logic [31:0] rdata;
  logic        unused_ok;

  assign acc      = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wr       = acc & wbs_we_i;
  assign rd       = acc & ~wbs_we_i;
  assign hit      = (wbs_adr_i[7:4] == 4'd0);
  assign reg_sel  = wbs_adr_i[3:2];
  assign busy     = (state_q != S_IDLE);
  assign wr_data  = wr & hit & (reg_sel == REG_DATA) & wbs_sel_i[0];
  assign start    = wr_data & ~busy & en_q;
  assign data_ovr = wr_data & (busy | ~en_q);
  assign w1c_done = wr & hit & (reg_sel == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_DONE];
  assign w1c_ovr  = wr & hit & (reg_sel == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_OVR];
  assign abort    = busy & ~en_q;
  assign finish   = (state_q == S_TRAIL) & half_tick & en_q;
  // edge_q[0]==0 marks the odd (leading) SCK edge of each bit
  assign sample_edge = (edge_q[0] == cpha_l);
  assign unused_ok = ^{wbs_dat_i[31:16], wbs_adr_i[1:0], wbs_sel_i[3:2]};

  // Idle reload tracks the live DIV so the first half-period of a new transfer
  // already uses the value latched on the start edge.
  assign div_src = busy ? div_l : div_q;

  spi_clkgen u_clkgen (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .run       (busy),
    .div       (div_src),
    .half_tick (half_tick)
  );

  always_comb begin
    cs_sel = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      cs_sel[i] = csm_q[i];
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        REG_CTRL:   rdata = {24'd0, csm_q, irqen_q, cpha_q, cpol_q, en_q};
        REG_DIV:    rdata = {16'd0, div_q};
        REG_DATA:   rdata = {24'd0, rx_q};
        REG_STATUS: rdata = {29'd0, ovr_q, done_q, busy};
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      irqen_q <= 1'b0;
      csm_q   <= '0;
      div_q   <= DIV_RST;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ack_q <= acc;
      dat_q <= rd ? rdata : '0;
      if (wr && hit && reg_sel == REG_CTRL && wbs_sel_i[0]) begin
        en_q    <= wbs_dat_i[CTRL_EN];
        cpol_q  <= wbs_dat_i[CTRL_CPOL];
        cpha_q  <= wbs_dat_i[CTRL_CPHA];
        irqen_q <= wbs_dat_i[CTRL_IRQEN];
        csm_q   <= wbs_dat_i[CTRL_CS_LSB +: 4];
      end
      if (wr && hit && reg_sel == REG_DIV) begin
        if (wbs_sel_i[0]) div_q[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) div_q[15:8] <= wbs_dat_i[15:8];
      end
      done_q <= finish | (done_q & ~w1c_done);
      ovr_q  <= data_ovr | (ovr_q & ~w1c_ovr);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_q     <= '0;
      edge_q   <= '0;
      sck_q    <= 1'b0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      div_l    <= DIV_RST;
      cs_sel_l <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
      sck_q   <= cpol_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          sck_q <= cpol_q;
          if (start) begin
            state_q  <= S_LEAD;
            tx_sh    <= wbs_dat_i[7:0];
            rx_sh    <= '0;
            edge_q   <= '0;
            cpol_l   <= cpol_q;
            cpha_l   <= cpha_q;
            div_l    <= div_q;
            cs_sel_l <= cs_sel;
          end
        end
        S_LEAD: begin
          if (half_tick) state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (half_tick) begin
            sck_q  <= ~sck_q;
            edge_q <= edge_q + 4'd1;
            // cpha=1 already presents the MSB at LEAD, so its first drive edge is a no-op
            if (sample_edge) rx_sh <= {rx_sh[6:0], miso_i};
            else if (edge_q != 4'd0) tx_sh <= {tx_sh[6:0], 1'b0};
            if (edge_q == 4'd15) state_q <= S_TRAIL;
          end
        end
        S_TRAIL: begin
          sck_q <= cpol_l;
          if (finish) begin
            state_q <= S_IDLE;
            rx_q    <= rx_sh;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = done_q & irqen_q;
  assign sck_o     = sck_q;
  assign mosi_o    = tx_sh[7];
  assign cs_n_o    = busy ? ~cs_sel_l : '1;
  assign spi_oeb_o = ~en_q;

endmodule

// File: tb/tb_wb_spi_master.sv
// Self-checking bench for wb_spi_master: bus reads and SPI frames are checked
// against expectations queued when the stimulus is issued.
module tb_wb_spi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [7:0]  adr;
  logic [31:0] dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq, sck, mosi, miso, oeb;
  logic [3:0]  cs_n;

  always #5 clk = ~clk;

  wb_spi_master #(.NCS(4), .DIV_RST(16'h0003)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .irq_o     (irq),
    .sck_o     (sck),
    .mosi_o    (mosi),
    .miso_i    (miso),
    .cs_n_o    (cs_n),
    .spi_oeb_o (oeb)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd_q[$];
  logic [7:0]  mosi_q[$];
  int          len_q[$];
  logic [3:0]  csv_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: loopback or shifts out s_tx, captures MOSI per mode.
  logic       s_cpol = 1'b0, s_cpha = 1'b0, loopback = 1'b0;
  logic [7:0] s_tx = 8'h00;
  logic       sl_miso = 1'b0;
  assign miso = loopback ? mosi : sl_miso;

  initial begin
    logic       prev_sck;
    logic [3:0] prev_cs, cs_first;
    logic [7:0] sl_sh, sl_rx;
    logic       lead, cs_stable;
    int         cs_len;
    prev_sck = 1'b0; prev_cs = 4'hF; cs_first = 4'hF;
    sl_sh = '0; sl_rx = '0; cs_len = 0; cs_stable = 1'b1;
    forever begin
      @(negedge clk);
      if (cs_n != 4'hF) begin
        if (prev_cs == 4'hF) begin
          cs_len = 1; cs_first = cs_n; cs_stable = 1'b1;
          sl_rx = '0; sl_sh = s_tx; sl_miso = sl_sh[7];
          if (!s_cpha) sl_sh = sl_sh << 1;
        end else begin
          cs_len++;
          if (cs_n != cs_first) cs_stable = 1'b0;
          if (sck != prev_sck) begin
            lead = (prev_sck == s_cpol);
            if (lead ^ s_cpha) sl_rx = {sl_rx[6:0], mosi};
            else begin
              sl_miso = sl_sh[7];
              sl_sh = sl_sh << 1;
            end
          end
        end
      end else if (prev_cs != 4'hF && mosi_q.size() > 0) begin
        check("mosi_byte", {24'd0, sl_rx}, {24'd0, mosi_q.pop_front()});
        check("cs_len", cs_len, len_q.pop_front());
        check("cs_val", {27'd0, cs_stable, cs_first}, {27'd0, 1'b1, csv_q.pop_front()});
      end
      prev_sck = sck;
      prev_cs  = cs_n;
    end
  end

  task automatic wb_cycle(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    logic got;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    r = '0; got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        r = dat_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_cycle(1'b1, a, d, s, r);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    rd_q.push_back(exp);
    wb_cycle(1'b0, a, 32'd0, 4'hF, r);
    check(tag, r, rd_q.pop_front());
  endtask

  task automatic start_xfer(input logic [7:0] tx, input int len, input logic [3:0] csv);
    mosi_q.push_back(tx);
    len_q.push_back(len);
    csv_q.push_back(csv);
    wb_write(8'h08, {24'd0, tx}, 4'h1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 2000 && cs_n != 4'hF; n++) begin
      @(posedge clk); #1;
    end
    if (cs_n != 4'hF) check("xfer_timeout", {28'd0, cs_n}, 32'hF);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},   {28'd0, cs_n}, 32'hF);
    check({tag, "_sck"},  {31'd0, sck},  32'd0);
    check({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
    check({tag, "_oeb"},  {31'd0, oeb},  32'd1);
    check({tag, "_irq"},  {31'd0, irq},  32'd0);
    check({tag, "_ack"},  {31'd0, ack},  32'd0);
    check({tag, "_dat"},  dat_o,         32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = '0; adr = '0; dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    read_expect("rst_ctrl", 8'h00, 32'h0);
    read_expect("rst_div", 8'h04, 32'h3);
    read_expect("rst_data", 8'h08, 32'h0);
    read_expect("rst_status", 8'h0C, 32'h0);
    check("ack_high", {31'd0, ack}, 32'd1);
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    read_expect("unmapped_rd", 8'h14, 32'h0);
    wb_write(8'h04, 32'h0000_5500, 4'h2);
    read_expect("div_lane1", 8'h04, 32'h5503);

    // Mode 0, DIV=0, slave returns 0x3C
    wb_write(8'h04, 32'h0, 4'h3);
    wb_write(8'h00, 32'h11, 4'h1);
    check("oeb_enabled", {31'd0, oeb}, 32'd0);
    s_tx = 8'h3C; s_cpol = 1'b0; s_cpha = 1'b0;
    start_xfer(8'hA5, 18, 4'hE);
    wait_idle();
    read_expect("m0_data", 8'h08, 32'h3C);
    read_expect("m0_status", 8'h0C, 32'h2);
    wb_write(8'h0C, 32'h2, 4'h1);
    read_expect("m0_w1c", 8'h0C, 32'h0);

    // Modes 1..3, DIV=3, loopback
    loopback = 1'b1;
    wb_write(8'h04, 32'h3, 4'h3);
    for (int m = 1; m < 4; m++) begin
      logic [31:0] ctrl;
      s_cpol = m[1]; s_cpha = m[0];
      ctrl = 32'h11 | (32'(m[1]) << 1) | (32'(m[0]) << 2);
      wb_write(8'h00, ctrl, 4'h1);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("m%0d_sck_idle", m), {31'd0, sck}, {31'd0, s_cpol});
      start_xfer(8'h81, 72, 4'hE);
      wait_idle();
      check($sformatf("m%0d_sck_after", m), {31'd0, sck}, {31'd0, s_cpol});
      read_expect($sformatf("m%0d_data", m), 8'h08, 32'h81);
      read_expect($sformatf("m%0d_status", m), 8'h0C, 32'h2);
      wb_write(8'h0C, 32'h2, 4'h1);
    end

    // Overrun during busy, then while disabled
    s_cpol = 1'b0; s_cpha = 1'b0;
    wb_write(8'h00, 32'h11, 4'h1);
    start_xfer(8'h5A, 72, 4'hE);
    repeat (10) @(posedge clk);
    #1;
    wb_write(8'h08, 32'hFF, 4'h1);
    read_expect("ovr_busy_status", 8'h0C, 32'h5);
    wait_idle();
    read_expect("ovr_data", 8'h08, 32'h5A);
    read_expect("ovr_status", 8'h0C, 32'h6);
    wb_write(8'h0C, 32'h6, 4'h1);
    read_expect("ovr_w1c", 8'h0C, 32'h0);
    wb_write(8'h00, 32'h10, 4'h1);
    wb_write(8'h08, 32'h33, 4'h1);
    check("dis_cs", {28'd0, cs_n}, 32'hF);
    read_expect("dis_status", 8'h0C, 32'h4);
    wb_write(8'h0C, 32'h4, 4'h1);

    // IRQ, and W1C of done on the completion edge
    wb_write(8'h00, 32'h19, 4'h1);
    check("irq_low", {31'd0, irq}, 32'd0);
    start_xfer(8'hC3, 72, 4'hE);
    wait_idle();
    check("irq_high", {31'd0, irq}, 32'd1);
    start_xfer(8'h3C, 72, 4'hE);
    repeat (71) @(posedge clk);
    #1;
    wb_write(8'h0C, 32'h2, 4'h1);
    wait_idle();
    read_expect("done_set_wins", 8'h0C, 32'h2);
    check("irq_kept", {31'd0, irq}, 32'd1);

    // Reset in the middle of SHIFT
    wb_write(8'h08, 32'hE7, 4'h1);
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_cs", {28'd0, cs_n}, 32'hE);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    read_expect("midrst_ctrl", 8'h00, 32'h0);
    read_expect("midrst_div", 8'h04, 32'h3);
    read_expect("midrst_data", 8'h08, 32'h0);
    read_expect("midrst_status", 8'h0C, 32'h0);

    // Abort by clearing enable in the middle of SHIFT
    wb_write(8'h00, 32'h11, 4'h1);
    wb_write(8'h08, 32'h96, 4'h1);
    repeat (20) @(posedge clk);
    #1;
    wb_write(8'h00, 32'h10, 4'h1);
    check("abort_cs_hold", {28'd0, cs_n}, 32'hE);
    @(posedge clk); #1;
    check("abort_cs", {28'd0, cs_n}, 32'hF);
    check("abort_oeb", {31'd0, oeb}, 32'd1);
    read_expect("abort_status", 8'h0C, 32'h0);
    read_expect("abort_data", 8'h08, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_spi_master.md
# wb_spi_master

Wishbone-slave SPI master for the user-project peripheral map, occupying the 4 KB slot at 0x3000_6000 alongside the PTC, I2C and RTC slaves. The top-level address decoder qualifies the strobe and drives `wbs_adr_i[7:0]`. This block answers with a one-cycle registered ack, which the top level ORs into its own ack/data return path. It runs single-byte, full-duplex SPI transfers in modes 0–3 with a programmable SCK divider, four chip selects and a completion interrupt.

## Interface
- `NCS`, default 4: number of active-low chip-select outputs.
- `DIV_RST`, default 16'h0003: reset value of the divider register.

Ports (clock and reset first):
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_stb_i`  in  1  strobe, already qualified by the slot select.
- `wbs_cyc_i`  in  1  bus cycle.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte lanes; a write updates only the selected lanes.
- `wbs_adr_i`  in  8  byte offset; bits [3:2] select the register.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered ack.
- `wbs_dat_o`  out  32  read data, valid with ack, 0 otherwise.
- `irq_o`  out  1  level interrupt = `done & irq_en`.
- `sck_o`  out  1  SPI clock.
- `mosi_o`  out  1  serial data out.
- `miso_i`  in  1  serial data in.
- `cs_n_o`  out  NCS  chip selects, active low.
- `spi_oeb_o`  out  1  pad output-enable bar for SCK, MOSI and CS; equals `~enable`.

## Operation
- Register map:
  - 0x0 CTRL: bit0 `enable`, bit1 `cpol`, bit2 `cpha`, bit3 `irq_en`, [7:4] `cs_mask`.
  - 0x4 DIV: [15:0]. SCK half-period is DIV+1 clocks.
  - 0x8 DATA: a write of [7:0] starts a transfer; a read returns the last received byte.
  - 0xC STATUS: bit0 `busy` (RO), bit1 `done` (sticky, W1C), bit2 `ovr` (sticky, W1C).
- A DATA write is ignored and sets `ovr` when `busy`=1 or `enable`=0.
- Writes to CTRL `cpol`/`cpha` or to DIV while `busy`=1 take effect on the next transfer; the active transfer uses values latched at start.
- FSM: IDLE → LEAD → SHIFT → TRAIL → IDLE.
  - IDLE: `sck_o` = cpol, `cs_n_o` all 1.
  - LEAD: lasts 1 half-period. `cs_n_o[i]` = ~`cs_mask[i]`; MSB driven on `mosi_o` at entry.
  - SHIFT: 16 half-periods, SCK toggling. With cpha=0, sample MISO on odd edges and shift on even edges. With cpha=1, shift on odd edges and sample on even edges. Transfer is MSB first.
  - TRAIL: 1 half-period, SCK at idle level.
  - On exit to IDLE: CS deasserted, rx byte written to DATA, `done` set.
- `enable` cleared mid-transfer: abort to IDLE next clock, CS high, `done` not set, rx data discarded.
- `done` set and W1C in the same cycle: set wins.
- Unused address bits and reads of reserved bits return 0.

## Timing
- Ack: `stb&cyc&~ack` registers `ack`=1 for exactly one cycle. Back-to-back strobes are acked every other cycle.
- Register write and transfer start take effect on the ack edge; `busy` reads 1 from that edge.
- Transfer length is `busy` high for 18·(DIV+1) clocks: LEAD (DIV+1), SHIFT 16·(DIV+1), TRAIL (DIV+1).
- `irq_o` rises on the same edge as `done`.
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0.
  - `sck_o`=0, `mosi_o`=0, `cs_n_o`=all 1, `spi_oeb_o`=1.
  - CTRL=0, DIV=`DIV_RST`, DATA=0, STATUS=0.
- Reset mid-transfer: all outputs take reset values on the next edge; no partial byte survives.
- DIV=0 gives SCK = clk/2; DIV=16'hFFFF gives 65536-clock half-periods with no counter overflow (17-bit compare is not allowed; the counter is 16-bit and wraps only at reload).

## Structure
- `spi_pkg`: register offsets, CTRL/STATUS bit indices, FSM state enum, and `DIV_RST`.
- Sub-module `spi_clkgen`: 16-bit down-counter issuing a one-cycle `half_tick` every DIV+1 clocks while running, held in reload when idle.
- The FSM, shift register and Wishbone register file live in `wb_spi_master`.

## Test plan
- Reset: release reset, read all four registers → 0x0, 0x3, 0x0, 0x0. Check `cs_n_o`=4'hF and `ack` is one cycle per access.
- Mode 0, DIV=0, `cs_mask`=1: write DATA=0xA5 with a slave model returning 0x3C → MOSI shows 1010_0101, `cs_n_o`=4'hE for 18 clocks, DATA reads 0x3C, `done`=1.
- Modes 1/2/3, DIV=3: byte 0x81 loopback (MISO=MOSI) → DATA=0x81 each time, SCK idle level = cpol, `busy` lasts 72 clocks.
- Overrun: DATA write during `busy` → `ovr`=1, in-flight byte unchanged. W1C 0x6 clears both `done` and `ovr`.
- IRQ: `irq_en`=1, complete a transfer → `irq_o`=1. Clear `done` in the same cycle as the next completion → `done` stays 1.
- Abort/reset: clear `enable` mid-SHIFT → CS high next clock, `done`=0. Assert `wb_rst_i` mid-SHIFT → all reset values the next cycle.
